// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA) with a valid/ready handshake, a global stall and tag pass-through.
// Optional rotate-right on mode 11 when SHIFT_UNIT_ROTATE_EN is defined; otherwise mode 11 acts as SLL.
module shift_unit_pipe #(
    parameter int N     = 32,
    parameter int LPS   = 1,
    parameter int TAG_W = 5,
    localparam int K    = $clog2(N),
    localparam int L    = (K + LPS - 1) / LPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [K-1:0]     b,
    input  logic [1:0]       mode,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     r,
    output logic [TAG_W-1:0] tag_out
);

    // One mux level: shift/rotate by sh; the SRA fill uses the sign captured at issue.
    function automatic logic [N-1:0] level_shift(input logic [N-1:0] d, input int unsigned sh,
                                                 input logic [1:0] m, input logic sgn);
        logic [N-1:0] res;
        case (m)
            2'b01:   res = d >> sh;
            2'b10:   res = (d >> sh) | (~({N{1'b1}} >> sh) & {N{sgn}});
`ifdef SHIFT_UNIT_ROTATE_EN
            2'b11:   res = (d >> sh) | (d << (N - sh));
`endif
            default: res = d << sh;
        endcase
        return res;
    endfunction

    logic stall;

    assign stall     = g_stage[L-1].valid_q && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = g_stage[L-1].valid_q;
    assign r         = g_stage[L-1].data_q;
    assign tag_out   = g_stage[L-1].tag_q;

    for (genvar s = 0; s < L; s++) begin : g_stage
        logic             src_valid;
        logic [N-1:0]     src_data;
        logic [K-1:0]     src_b;
        logic [1:0]       src_mode;
        logic             src_sign;
        logic [TAG_W-1:0] src_tag;
        logic [N-1:0]     shifted;
        logic             valid_q, valid_d;
        logic [N-1:0]     data_q, data_d;
        logic [TAG_W-1:0] tag_q, tag_d;

        if (s == 0) begin : g_src_in
            assign src_valid = in_valid;
            assign src_data  = a;
            assign src_b     = b;
            assign src_mode  = mode;
            assign src_sign  = (mode == 2'b10) && a[N-1];
            assign src_tag   = tag_in;
        end else begin : g_src_prev
            assign src_valid = g_stage[s-1].valid_q;
            assign src_data  = g_stage[s-1].data_q;
            assign src_b     = g_stage[s-1].g_ctl.b_q;
            assign src_mode  = g_stage[s-1].g_ctl.mode_q;
            assign src_sign  = g_stage[s-1].g_ctl.sign_q;
            assign src_tag   = g_stage[s-1].tag_q;
        end

        // Apply this stage's LPS mux levels; levels past K-1 do not exist.
        always_comb begin
            logic [K-1:0] b_sh;
            shifted = src_data;
            b_sh    = '0;
            for (int l = 0; l < LPS; l++) begin
                if ((s * LPS + l) < K) begin
                    b_sh = src_b >> (s * LPS + l);
                    if (b_sh[0]) begin
                        shifted = level_shift(shifted, 32'd1 << (s * LPS + l), src_mode, src_sign);
                    end else begin
                        shifted = shifted;
                    end
                end else begin
                    shifted = shifted;
                end
            end
        end

        // Stall freezes every stage; otherwise bubbles and data advance alike.
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            tag_d   = tag_q;
            if (stall) begin
                valid_d = valid_q;
                data_d  = data_q;
                tag_d   = tag_q;
            end else begin
                valid_d = src_valid;
                data_d  = shifted;
                tag_d   = src_tag;
            end
        end

        // Stage register for valid, data and tag.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                tag_q   <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
                tag_q   <= tag_d;
            end
        end

        // Shift controls are only needed by later stages, so the last stage drops them.
        if (s < L - 1) begin : g_ctl
            logic [K-1:0] b_q, b_d;
            logic [1:0]   mode_q, mode_d;
            logic         sign_q, sign_d;

            // Hold or advance the remaining shift controls with the data.
            always_comb begin
                b_d    = b_q;
                mode_d = mode_q;
                sign_d = sign_q;
                if (stall) begin
                    b_d    = b_q;
                    mode_d = mode_q;
                    sign_d = sign_q;
                end else begin
                    b_d    = src_b;
                    mode_d = src_mode;
                    sign_d = src_sign;
                end
            end

            // Control register travelling alongside the stage data.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    b_q    <= '0;
                    mode_q <= 2'b00;
                    sign_q <= 1'b0;
                end else begin
                    b_q    <= b_d;
                    mode_q <= mode_d;
                    sign_q <= sign_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Self-checking bench for shift_unit_pipe: three builds (LPS=1,2,5) share stimulus; LPS=1 gets full scoreboard checks.
module tb_shift_unit_pipe;
    localparam int N  = 32;
    localparam int TW = 5;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  b;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  b;
        logic [1:0]  mode;
        logic [4:0]  tag;
        logic [31:0] exp;
    } req_t;

    typedef struct {
        logic [31:0] r;
        logic [4:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [4:0]  b;
    logic [1:0]  mode;
    logic [4:0]  tag_in;
    logic        ir [3];
    logic        ov [3];
    logic [31:0] rr [3];
    logic [4:0]  to [3];

    int n_cmp  = 0;
    int n_fail = 0;
    int n_out  = 0;
    int n_irlo = 0;
    req_t rq [$];
    exp_t sb [$];
    logic        stalled_prev = 1'b0;
    logic [31:0] prev_r;
    logic [4:0]  prev_tag;
    int lat [3] = '{5, 3, 1};

    always #5 clk = ~clk;

    shift_unit_pipe #(.N(N), .LPS(1), .TAG_W(TW)) u_lps1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .mode(mode),
        .tag_in(tag_in), .out_valid(ov[0]), .out_ready(out_ready), .r(rr[0]), .tag_out(to[0]));
    shift_unit_pipe #(.N(N), .LPS(2), .TAG_W(TW)) u_lps2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .mode(mode),
        .tag_in(tag_in), .out_valid(ov[1]), .out_ready(out_ready), .r(rr[1]), .tag_out(to[1]));
    shift_unit_pipe #(.N(N), .LPS(5), .TAG_W(TW)) u_lps5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b), .mode(mode),
        .tag_in(tag_in), .out_valid(ov[2]), .out_ready(out_ready), .r(rr[2]), .tag_out(to[2]));

    // Reference: plain shift operators on the whole word.
    function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] sh, input logic [1:0] m);
        int amt;
        logic [31:0] t;
        logic [63:0] dd;
        amt = int'(sh);
        case (m)
            2'b00: t = x << amt;
            2'b01: t = x >> amt;
            2'b10: t = $signed(x) >>> amt;
            default: begin
`ifdef SHIFT_UNIT_ROTATE_EN
                dd = {x, x} >> amt;
                t  = dd[31:0];
`else
                dd = 64'd0;
                t  = x << amt;
`endif
            end
        endcase
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    task automatic push_req(input logic [31:0] xa, input logic [4:0] xb, input logic [1:0] xm,
                            input logic [4:0] xt, input logic [31:0] xe);
        req_t q;
        q.a = xa; q.b = xb; q.mode = xm; q.tag = xt; q.exp = xe;
        rq.push_back(q);
    endtask

    // One clock of the LPS=1 scoreboard flow; entered and left at posedge+1.
    task automatic cycle(input logic ordy);
        exp_t e;
        if (rq.size() > 0) begin
            in_valid = 1'b1; a = rq[0].a; b = rq[0].b; mode = rq[0].mode; tag_in = rq[0].tag;
        end else begin
            in_valid = 1'b0;
        end
        out_ready = ordy;
        #1;
        chk("in_ready", {31'd0, ir[0]}, {31'd0, !(ov[0] && !ordy)});
        if (!ir[0]) n_irlo++;
        if (stalled_prev && ov[0]) begin
            chk("stall_hold_r", rr[0], prev_r);
            chk("stall_hold_tag", {27'd0, to[0]}, {27'd0, prev_tag});
        end
        if (ov[0] && ordy) begin
            n_out++;
            if (sb.size() == 0) begin
                fail_now("spurious_result");
            end else begin
                e = sb.pop_front();
                chk("result_r", rr[0], e.r);
                chk("result_tag", {27'd0, to[0]}, {27'd0, e.tag});
            end
        end
        if (in_valid && ir[0]) begin
            e.r = rq[0].exp;
            e.tag = rq[0].tag;
            sb.push_back(e);
            void'(rq.pop_front());
        end
        stalled_prev = ov[0] && !ordy;
        prev_r = rr[0];
        prev_tag = to[0];
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int maxc, input int pct);
        int c;
        c = 0;
        while ((rq.size() > 0 || sb.size() > 0) && c < maxc) begin
            cycle($urandom_range(99) < pct);
            c++;
        end
        if (rq.size() > 0 || sb.size() > 0) fail_now("drain_timeout");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [12];
        logic [31:0] s1_exp [5];
        logic [4:0]  s1_b [5];
        int j;
        logic [4:0]  rb;
        logic [1:0]  rm;
        logic [31:0] ra;

        tbl[0]  = '{32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000};
        tbl[1]  = '{32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000};
        tbl[2]  = '{32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000};
`ifdef SHIFT_UNIT_ROTATE_EN
        tbl[3]  = '{32'h0000_0001, 5'd1,  2'b11, 32'h8000_0000};
        tbl[11] = '{32'hF000_0001, 5'd4,  2'b11, 32'h1F00_0000};
`else
        tbl[3]  = '{32'h0000_0001, 5'd1,  2'b11, 32'h0000_0002};
        tbl[11] = '{32'hF000_0001, 5'd4,  2'b11, 32'h0000_0010};
`endif
        tbl[4]  = '{32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678};
        tbl[5]  = '{32'h1234_5678, 5'd0,  2'b01, 32'h1234_5678};
        tbl[6]  = '{32'h1234_5678, 5'd0,  2'b10, 32'h1234_5678};
        tbl[7]  = '{32'h1234_5678, 5'd0,  2'b11, 32'h1234_5678};
        tbl[8]  = '{32'h8000_0000, 5'd4,  2'b00, 32'h0000_0000};
        tbl[9]  = '{32'hFFFF_FFFF, 5'd31, 2'b01, 32'h0000_0001};
        tbl[10] = '{32'h8000_0001, 5'd1,  2'b10, 32'hC000_0000};
        s1_b   = '{5'd1, 5'd3, 5'd7, 5'd15, 5'd31};
        s1_exp = '{32'h0000_0002, 32'h0000_0008, 32'h0000_0080, 32'h0000_8000, 32'h8000_0000};

        // Reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = 32'd0; b = 5'd0; mode = 2'b00; tag_in = 5'd0;
        #2;
        for (int d = 0; d < 3; d++) begin
            chk("reset_out_valid", {31'd0, ov[d]}, 32'd0);
            chk("reset_r", rr[d], 32'd0);
            chk("reset_tag", {27'd0, to[d]}, 32'd0);
        end
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk("in_ready_after_reset", {31'd0, ir[d]}, 32'd1);
        @(posedge clk); #1;

        // Latency and SLL results for all three builds
        in_valid = 1'b1; a = 32'h1; b = s1_b[0]; mode = 2'b00; tag_in = 5'd1;
        @(posedge clk); #1;
        for (int c = 0; c < 9; c++) begin
            if (c + 1 < 5) begin
                b = s1_b[c+1]; tag_in = 5'(c + 2);
            end else begin
                in_valid = 1'b0;
            end
            for (int d = 0; d < 3; d++) begin
                j = c - (lat[d] - 1);
                if (j >= 0 && j < 5) begin
                    chk($sformatf("lat_valid_L%0d_c%0d", lat[d], c), {31'd0, ov[d]}, 32'd1);
                    chk($sformatf("lat_r_L%0d_c%0d", lat[d], c), rr[d], s1_exp[j]);
                    chk($sformatf("lat_tag_L%0d_c%0d", lat[d], c), {27'd0, to[d]}, 32'(j + 1));
                end else begin
                    chk($sformatf("lat_idle_L%0d_c%0d", lat[d], c), {31'd0, ov[d]}, 32'd0);
                end
            end
            @(posedge clk); #1;
        end

        // Table-driven mode and boundary vectors
        for (int i = 0; i < 12; i++) push_req(tbl[i].a, tbl[i].b, tbl[i].mode, 5'(i + 8), tbl[i].exp);
        drain(60, 100);

        // 8 back-to-back requests, 3-cycle stall at first valid result
        for (int i = 0; i < 8; i++) begin
            ra = $urandom; rb = 5'($urandom); rm = 2'($urandom);
            push_req(ra, rb, rm, 5'(i), ref_shift(ra, rb, rm));
        end
        n_irlo = 0; n_out = 0;
        begin
            int left;
            bit started;
            int c;
            left = 3; started = 1'b0; c = 0;
            while ((rq.size() > 0 || sb.size() > 0) && c < 60) begin
                if (ov[0]) started = 1'b1;
                if (started && left > 0) begin
                    left--;
                    cycle(1'b0);
                end else begin
                    cycle(1'b1);
                end
                c++;
            end
            if (rq.size() > 0 || sb.size() > 0) fail_now("stall_drain_timeout");
        end
        chk("stall_in_ready_low_cycles", 32'(n_irlo), 32'd3);
        chk("stall_result_count", 32'(n_out), 32'd8);

        // Randomized traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            if (rq.size() == 0 && $urandom_range(3) != 0) begin
                ra = $urandom; rb = 5'($urandom); rm = 2'($urandom);
                push_req(ra, rb, rm, 5'($urandom), ref_shift(ra, rb, rm));
            end
            cycle($urandom_range(99) < 70);
        end
        drain(200, 70);

        // Reset while three operations are in flight
        for (int i = 0; i < 3; i++) push_req(32'hA5A5_0000 + 32'(i), 5'd3, 2'b00, 5'(20 + i), ref_shift(32'hA5A5_0000 + 32'(i), 5'd3, 2'b00));
        for (int i = 0; i < 4; i++) cycle(1'b1);
        cycle(1'b0);
        chk("pre_reset_out_valid", {31'd0, ov[0]}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_out_valid", {31'd0, ov[0]}, 32'd0);
        chk("async_reset_r", rr[0], 32'd0);
        chk("async_reset_tag", {27'd0, to[0]}, 32'd0);
        sb.delete(); rq.delete(); stalled_prev = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        n_out = 0;
        for (int i = 0; i < 8; i++) cycle(1'b1);
        chk("no_stale_after_reset", 32'(n_out), 32'd0);
        push_req(32'h1, 5'd2, 2'b00, 5'd7, 32'h0000_0004);
        drain(20, 100);
        chk("fresh_after_reset_count", 32'(n_out), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
